// File: rtl/cnn_stream_pkg.sv
// Shared types for the pixel stream and the conv/Relu chain.
// Holds the stream FSM states, the pixel type and the raster address width.
package cnn_stream_pkg;

    localparam int PIXEL_W = 8;

    typedef logic signed [PIXEL_W-1:0] pixel_t;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DRAIN
    } stream_state_t;

    function automatic int raster_addr_width(input int side);
        return (side * side > 1) ? $clog2(side * side) : 1;
    endfunction

endpackage

// File: rtl/pixel_stream_source_if.sv
// Host write port, start/hold controls and the outgoing pixel stream.
// Master drives writes and controls; slave is the stream source.
interface pixel_stream_source_if
    import cnn_stream_pkg::*;
#(
    parameter int bitwidth   = 8,
    parameter int imageWidth = 11
);
    localparam int addrWidth = raster_addr_width(imageWidth);

    logic                       wr_en;
    logic [addrWidth-1:0]       wr_addr;
    logic signed [bitwidth-1:0] wr_data;
    logic                       start;
    logic                       hold_in;
    logic signed [bitwidth-1:0] data_out;
    logic                       isValid_out;
    logic                       rowEnd_out;
    logic                       frameEnd_out;
    logic                       busy;

    modport master (
        output wr_en, wr_addr, wr_data, start, hold_in,
        input  data_out, isValid_out, rowEnd_out, frameEnd_out, busy
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, start, hold_in,
        output data_out, isValid_out, rowEnd_out, frameEnd_out, busy
    );

endinterface

// File: rtl/pixel_frame_ram.sv
// Single-port frame buffer: synchronous write, registered read.
// Contents are never reset; only the read register is.
module pixel_frame_ram #(
    parameter int bitwidth  = 8,
    parameter int depth     = 121,
    parameter int addrWidth = 7
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       we,
    input  logic                       re,
    input  logic [addrWidth-1:0]       addr,
    input  logic signed [bitwidth-1:0] wdata,
    output logic signed [bitwidth-1:0] rdata
);
    logic signed [bitwidth-1:0] mem [depth];
    logic signed [bitwidth-1:0] rdata_d;
    logic signed [bitwidth-1:0] rdata_q;

    always_ff @(posedge clock) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    // Read data holds when no read is issued.
    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem[addr];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/pixel_stream_source.sv
// Buffers one square frame from the host and streams it in raster order
// with row-end/frame-end markers and downstream hold.
module pixel_stream_source
    import cnn_stream_pkg::*;
#(
    parameter int bitwidth   = 8,
    parameter int imageWidth = 11
) (
    input  logic                 clock,
    input  logic                 reset,
    pixel_stream_source_if.slave bus
);
    localparam int frameSize = imageWidth * imageWidth;
    localparam int addrWidth = raster_addr_width(imageWidth);
    localparam int colWidth  = $clog2(imageWidth);
    localparam logic [colWidth-1:0] LAST_IDX = colWidth'(imageWidth - 1);

    stream_state_t state_d, state_q;
    logic [colWidth-1:0] row_d, row_q;
    logic [colWidth-1:0] col_d, col_q;
    logic valid_d, valid_q;
    logic row_end_d, row_end_q;
    logic frame_end_d, frame_end_q;

    logic                 rd_en;
    logic                 ram_we;
    logic [addrWidth-1:0] rd_addr;
    logic [addrWidth-1:0] ram_addr;

    assign rd_addr = addrWidth'(int'(row_q) * imageWidth + int'(col_q));

    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        col_d       = col_q;
        rd_en       = 1'b0;
        valid_d     = 1'b0;
        row_end_d   = 1'b0;
        frame_end_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (!bus.hold_in) begin
                    rd_en       = 1'b1;
                    valid_d     = 1'b1;
                    row_end_d   = (col_q == LAST_IDX);
                    frame_end_d = row_end_d && (row_q == LAST_IDX);
                    if (col_q == LAST_IDX) begin
                        col_d = '0;
                        if (row_q == LAST_IDX) begin
                            row_d   = '0;
                            state_d = DRAIN;
                        end else begin
                            row_d = row_q + 1'b1;
                        end
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end
            DRAIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            row_q       <= '0;
            col_q       <= '0;
            valid_q     <= 1'b0;
            row_end_q   <= 1'b0;
            frame_end_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            col_q       <= col_d;
            valid_q     <= valid_d;
            row_end_q   <= row_end_d;
            frame_end_q <= frame_end_d;
        end
    end

    // Host writes only land while idle, so the port is never contended.
    assign ram_we   = bus.wr_en && (state_q == IDLE)
                      && (int'(bus.wr_addr) < frameSize);
    assign ram_addr = rd_en ? rd_addr : bus.wr_addr;

    pixel_frame_ram #(
        .bitwidth  (bitwidth),
        .depth     (frameSize),
        .addrWidth (addrWidth)
    ) u_ram (
        .clock (clock),
        .reset (reset),
        .we    (ram_we),
        .re    (rd_en),
        .addr  (ram_addr),
        .wdata (bus.wr_data),
        .rdata (bus.data_out)
    );

    assign bus.isValid_out  = valid_q;
    assign bus.rowEnd_out   = row_end_q;
    assign bus.frameEnd_out = frame_end_q;
    assign bus.busy         = (state_q != IDLE);

endmodule
